xadac_ex_issue: RTL and testbench
=================================

Name: xadac_ex_issue

Overview:
- Initiator (Master) end of the xadac_ex_if execute protocol.
- Accepts decoded xadac ops from the decode/dispatch stage and drives them into an execute unit (e.g. the vmacc slave) with valid/ready handshakes.
- Caps the number of in-flight ops, checks that responses return in issue order, and forwards results to a registered writeback port.

Parameters:
- IdWidth, 3, width of the transaction ID.
- XLEN, 32, scalar operand/result width.
- VectorWidth, 256, vector operand/result width.
- ImmWidth, 5, immediate width.
- MaxOutstanding, 4, maximum ops accepted but not yet retired on wb (power of 2, ≥2).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- in_valid_i  in  1  op valid from dispatch
- in_ready_o  out  1  op accepted when valid&ready
- in_id_i  in  IdWidth  op ID
- in_rs1_i, in_rs2_i  in  XLEN  scalar operands
- in_vs1_i, in_vs2_i, in_vs3_i  in  VectorWidth  vector operands
- in_imm_i  in  ImmWidth  immediate
- ex_req_valid_o  out  1  request valid to execute unit
- ex_req_ready_i  in  1  execute unit ready
- ex_req_id_o  out  IdWidth
- ex_req_rs1_o, ex_req_rs2_o  out  XLEN
- ex_req_vs1_o, ex_req_vs2_o, ex_req_vs3_o  out  VectorWidth
- ex_req_imm_o  out  ImmWidth
- ex_resp_valid_i  in  1  response valid
- ex_resp_ready_o  out  1  response accepted
- ex_resp_id_i  in  IdWidth
- ex_resp_rd_i  in  XLEN
- ex_resp_vd_i  in  VectorWidth
- wb_valid_o  out  1  result valid to writeback
- wb_ready_i  in  1  writeback ready
- wb_id_o  out  IdWidth
- wb_rd_o  out  XLEN
- wb_vd_o  out  VectorWidth
- busy_o  out  1  cnt != 0
- err_o  out  1  sticky ordering error

Behaviour:
- Reset (async, rst_ni=0): ex_req_valid_o=0, wb_valid_o=0, cnt=0, order FIFO empty, err_o=0, all data registers 0. Reset mid-transaction drops all in-flight state; no response is replayed.
- Handshakes: transfer on valid&ready. A valid, once raised, stays high with stable payload until accepted. in_ready_o does not depend on in_valid_i.
- Outstanding counter cnt (0..MaxOutstanding):
  - +1 on input accept; −1 on wb accept; both in the same cycle → unchanged.
  - in_ready_o = (cnt < MaxOutstanding) && (!ex_req_valid_o || ex_req_ready_i).
- Request stage: a single register.
  - On input accept it loads all in_* fields and sets ex_req_valid_o=1 the next cycle (1-cycle latency).
  - Accept on ex_req_ready_i with no new input clears ex_req_valid_o.
  - Back-to-back accept and load in the same cycle gives full throughput.
- Order FIFO: depth MaxOutstanding, holds IDs.
  - Push in_id_i on input accept; pop on ex_resp accept.
  - Push happens before the request is visible, so a zero-latency (combinational) slave always finds a head entry.
  - Pointers wrap modulo depth; an extra wrap bit distinguishes full from empty.
  - Push and pop in the same cycle are both performed.
- Response stage: a single register.
  - ex_resp_ready_o = !wb_valid_o || wb_ready_i.
  - On response accept it loads id/rd/vd and sets wb_valid_o=1 the next cycle (1-cycle latency).
  - wb accept with no new response clears wb_valid_o.
- Error (err_o): set on response accept if the FIFO is empty or ex_resp_id_i != FIFO head.
  - Sticky; cleared only by reset.
  - The offending response is still forwarded to wb and still pops the FIFO (if non-empty).
- busy_o is combinational from cnt.
- IDs are opaque: duplicate IDs in flight are legal; ordering is checked by position.

Test Plan:
- Single op: id=2, rs1=0x11, imm=3, slave ready=1, response id=2, rd=0, vd=vs3 in the same cycle → ex_req valid at cycle 1 with matching fields; wb_valid at cycle 2, wb_id=2; busy_o high from cycle 1 until the wb accept; err_o=0.
- Streaming: 8 ops, ids 0..7, ready always high, zero-latency slave → one op per cycle on ex_req and on wb, in order, no bubbles after fill; cnt ≤ 2.
- Credit limit: wb_ready_i=0, issue 6 ops → exactly 4 accepted, in_ready_o=0 with cnt=4; raise wb_ready_i → 4 retire in order, then the remaining 2 are accepted.
- Back-pressure: ex_req_ready_i=0 for 5 cycles while ex_req_valid_o=1 → payload stable every cycle; on release, one transfer and no duplication.
- Order error: issue ids 1 then 2, slave returns id 2 first → err_o=1 from the next cycle and stays 1; both responses still appear on wb (ids 2, 1).
- Reset mid-op: assert rst_ni=0 with 3 in flight and wb_valid_o=1 → all valids 0 and busy_o=0 immediately (async); after release, a new op id=5 completes normally with err_o=0.

Source files
------------

// File: rtl/xadac_ex_issue.sv
// Initiator side of the xadac execute interface: one request register toward the execute unit,
// one result register toward writeback, an in-flight credit counter and an in-order ID check.
module xadac_ex_issue #(
  parameter int unsigned IdWidth        = 3,
  parameter int unsigned XLEN           = 32,
  parameter int unsigned VectorWidth    = 256,
  parameter int unsigned ImmWidth       = 5,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [IdWidth-1:0]     in_id_i,
  input  logic [XLEN-1:0]        in_rs1_i,
  input  logic [XLEN-1:0]        in_rs2_i,
  input  logic [VectorWidth-1:0] in_vs1_i,
  input  logic [VectorWidth-1:0] in_vs2_i,
  input  logic [VectorWidth-1:0] in_vs3_i,
  input  logic [ImmWidth-1:0]    in_imm_i,
  output logic                   ex_req_valid_o,
  input  logic                   ex_req_ready_i,
  output logic [IdWidth-1:0]     ex_req_id_o,
  output logic [XLEN-1:0]        ex_req_rs1_o,
  output logic [XLEN-1:0]        ex_req_rs2_o,
  output logic [VectorWidth-1:0] ex_req_vs1_o,
  output logic [VectorWidth-1:0] ex_req_vs2_o,
  output logic [VectorWidth-1:0] ex_req_vs3_o,
  output logic [ImmWidth-1:0]    ex_req_imm_o,
  input  logic                   ex_resp_valid_i,
  output logic                   ex_resp_ready_o,
  input  logic [IdWidth-1:0]     ex_resp_id_i,
  input  logic [XLEN-1:0]        ex_resp_rd_i,
  input  logic [VectorWidth-1:0] ex_resp_vd_i,
  output logic                   wb_valid_o,
  input  logic                   wb_ready_i,
  output logic [IdWidth-1:0]     wb_id_o,
  output logic [XLEN-1:0]        wb_rd_o,
  output logic [VectorWidth-1:0] wb_vd_o,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef logic [CntW-1:0] cnt_t;
  localparam cnt_t MaxCnt = cnt_t'(MaxOutstanding);
  localparam cnt_t One    = cnt_t'(1);

  typedef struct packed {
    logic [IdWidth-1:0]     id;
    logic [XLEN-1:0]        rs1;
    logic [XLEN-1:0]        rs2;
    logic [VectorWidth-1:0] vs1;
    logic [VectorWidth-1:0] vs2;
    logic [VectorWidth-1:0] vs3;
    logic [ImmWidth-1:0]    imm;
  } req_t;

  typedef struct packed {
    logic [IdWidth-1:0]     id;
    logic [XLEN-1:0]        rd;
    logic [VectorWidth-1:0] vd;
  } resp_t;

  req_t               req_q;
  resp_t              resp_q;
  logic               req_vld, wb_vld, err_q;
  cnt_t               cnt;
  cnt_t               wr_ptr, rd_ptr;
  logic [IdWidth-1:0] fifo_mem [MaxOutstanding];

  logic               in_fire, ex_fire, resp_fire, wb_fire;
  logic               fifo_empty, id_bad;
  logic [IdWidth-1:0] fifo_head;

  // Credit is held from input accept until writeback accept, so the order FIFO never overflows.
  assign in_ready_o      = (cnt < MaxCnt) && (!req_vld || ex_req_ready_i);
  assign ex_resp_ready_o = !wb_vld || wb_ready_i;

  assign in_fire   = in_valid_i && in_ready_o;
  assign ex_fire   = req_vld && ex_req_ready_i;
  assign resp_fire = ex_resp_valid_i && ex_resp_ready_o;
  assign wb_fire   = wb_vld && wb_ready_i;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_head  = fifo_mem[rd_ptr[PtrW-1:0]];
  assign id_bad     = fifo_empty || (ex_resp_id_i != fifo_head);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_vld <= 1'b0;
      req_q   <= '0;
    end else if (in_fire) begin
      req_vld <= 1'b1;
      req_q   <= '{id: in_id_i, rs1: in_rs1_i, rs2: in_rs2_i, vs1: in_vs1_i,
                   vs2: in_vs2_i, vs3: in_vs3_i, imm: in_imm_i};
    end else if (ex_fire) begin
      req_vld <= 1'b0;
    end
  end

  // IDs enter at input accept, a cycle before the request is visible, so even a
  // combinational slave always finds its entry at the head.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(MaxOutstanding); i++) fifo_mem[i] <= '0;
    end else begin
      if (in_fire) begin
        fifo_mem[wr_ptr[PtrW-1:0]] <= in_id_i;
        wr_ptr <= wr_ptr + One;
      end
      if (resp_fire && !fifo_empty) rd_ptr <= rd_ptr + One;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_vld <= 1'b0;
      resp_q <= '0;
    end else if (resp_fire) begin
      wb_vld <= 1'b1;
      resp_q <= '{id: ex_resp_id_i, rd: ex_resp_rd_i, vd: ex_resp_vd_i};
    end else if (wb_fire) begin
      wb_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      cnt <= cnt + cnt_t'(in_fire) - cnt_t'(wb_fire);
      if (resp_fire && id_bad) err_q <= 1'b1;
    end
  end

  assign ex_req_valid_o = req_vld;
  assign ex_req_id_o    = req_q.id;
  assign ex_req_rs1_o   = req_q.rs1;
  assign ex_req_rs2_o   = req_q.rs2;
  assign ex_req_vs1_o   = req_q.vs1;
  assign ex_req_vs2_o   = req_q.vs2;
  assign ex_req_vs3_o   = req_q.vs3;
  assign ex_req_imm_o   = req_q.imm;

  assign wb_valid_o = wb_vld;
  assign wb_id_o    = resp_q.id;
  assign wb_rd_o    = resp_q.rd;
  assign wb_vd_o    = resp_q.vd;

  assign busy_o = (cnt != '0);
  assign err_o  = err_q;

endmodule

// File: tb/tb_xadac_ex_issue.sv
// Randomized bench for xadac_ex_issue: a transaction-level queue model predicts every
// output each cycle; directed phases cover single op, streaming, credits, stalls, ordering and reset.
module tb_xadac_ex_issue;
  localparam int IW = 3, XL = 32, VW = 256, IMW = 5, MO = 4;

  typedef struct packed {
    logic [IW-1:0]  id;
    logic [XL-1:0]  rs1;
    logic [XL-1:0]  rs2;
    logic [VW-1:0]  vs1;
    logic [VW-1:0]  vs2;
    logic [VW-1:0]  vs3;
    logic [IMW-1:0] imm;
  } op_t;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [XL-1:0] rd;
    logic [VW-1:0] vd;
  } res_t;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic in_v = 1'b0, req_rdy = 1'b0, resp_v = 1'b0, wb_rdy = 1'b0;
  op_t  in_op = '0;
  res_t resp  = '0;

  logic           in_ready_o, ex_req_valid_o, ex_resp_ready_o, wb_valid_o, busy_o, err_o;
  logic [IW-1:0]  ex_req_id_o, wb_id_o;
  logic [XL-1:0]  ex_req_rs1_o, ex_req_rs2_o, wb_rd_o;
  logic [VW-1:0]  ex_req_vs1_o, ex_req_vs2_o, ex_req_vs3_o, wb_vd_o;
  logic [IMW-1:0] ex_req_imm_o;

  always #5 clk_i = ~clk_i;

  xadac_ex_issue #(
    .IdWidth(IW), .XLEN(XL), .VectorWidth(VW), .ImmWidth(IMW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(in_v), .in_ready_o(in_ready_o), .in_id_i(in_op.id),
    .in_rs1_i(in_op.rs1), .in_rs2_i(in_op.rs2),
    .in_vs1_i(in_op.vs1), .in_vs2_i(in_op.vs2), .in_vs3_i(in_op.vs3), .in_imm_i(in_op.imm),
    .ex_req_valid_o(ex_req_valid_o), .ex_req_ready_i(req_rdy), .ex_req_id_o(ex_req_id_o),
    .ex_req_rs1_o(ex_req_rs1_o), .ex_req_rs2_o(ex_req_rs2_o),
    .ex_req_vs1_o(ex_req_vs1_o), .ex_req_vs2_o(ex_req_vs2_o), .ex_req_vs3_o(ex_req_vs3_o),
    .ex_req_imm_o(ex_req_imm_o),
    .ex_resp_valid_i(resp_v), .ex_resp_ready_o(ex_resp_ready_o), .ex_resp_id_i(resp.id),
    .ex_resp_rd_i(resp.rd), .ex_resp_vd_i(resp.vd),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_rdy), .wb_id_o(wb_id_o),
    .wb_rd_o(wb_rd_o), .wb_vd_o(wb_vd_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  int n_chk = 0, n_fail = 0;

  // Reference model: ops waiting for ex, ops at the slave, IDs in issue order, results for wb.
  op_t           req_q[$];
  op_t           slv_q[$];
  logic [IW-1:0] ord_q[$];
  res_t          wb_q[$];
  int            outst = 0;
  bit            m_err = 0;
  bit            l_in_f, l_resp_f;
  int            issue_left = 0;
  logic [IW-1:0] next_id = '0;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit pct(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  function automatic op_t rand_op(input logic [IW-1:0] id);
    op_t o;
    o.id  = id;
    o.rs1 = $urandom;
    o.rs2 = $urandom;
    for (int k = 0; k < VW / 32; k++) begin
      o.vs1[k*32 +: 32] = $urandom;
      o.vs2[k*32 +: 32] = $urandom;
      o.vs3[k*32 +: 32] = $urandom;
    end
    o.imm = IMW'($urandom);
    return o;
  endfunction

  function automatic res_t mk_res(input op_t o);
    return '{id: o.id, rd: o.rs1 + o.rs2, vd: o.vs3 ^ o.vs1};
  endfunction

  function automatic bit idle();
    return !in_v && !resp_v && req_q.size() == 0 && wb_q.size() == 0 &&
           slv_q.size() == 0 && outst == 0;
  endfunction

  task automatic model_clear();
    req_q.delete(); slv_q.delete(); ord_q.delete(); wb_q.delete();
    outst = 0; m_err = 0; issue_left = 0;
    in_v = 0; resp_v = 0; req_rdy = 0; wb_rdy = 0;
  endtask

  // Entered at posedge+1 with inputs driven; checks, advances the model, returns at next posedge+1.
  task automatic step();
    bit e_in_rdy, e_resp_rdy, in_f, ex_f, resp_f, wb_f;
    #1;
    e_in_rdy   = (outst < MO) && (req_q.size() == 0 || req_rdy);
    e_resp_rdy = (wb_q.size() == 0) || wb_rdy;
    chk("in_ready", in_ready_o, e_in_rdy);
    chk("resp_ready", ex_resp_ready_o, e_resp_rdy);
    chk("req_valid", ex_req_valid_o, req_q.size() != 0);
    if (req_q.size() != 0) begin
      chk("req_id", ex_req_id_o, req_q[0].id);
      chk("req_rs1", ex_req_rs1_o, req_q[0].rs1);
      chk("req_rs2", ex_req_rs2_o, req_q[0].rs2);
      chk("req_vs1", ex_req_vs1_o, req_q[0].vs1);
      chk("req_vs2", ex_req_vs2_o, req_q[0].vs2);
      chk("req_vs3", ex_req_vs3_o, req_q[0].vs3);
      chk("req_imm", ex_req_imm_o, req_q[0].imm);
    end
    chk("wb_valid", wb_valid_o, wb_q.size() != 0);
    if (wb_q.size() != 0) begin
      chk("wb_id", wb_id_o, wb_q[0].id);
      chk("wb_rd", wb_rd_o, wb_q[0].rd);
      chk("wb_vd", wb_vd_o, wb_q[0].vd);
    end
    chk("busy", busy_o, outst != 0);
    chk("err", err_o, m_err);

    in_f   = in_v && e_in_rdy;
    ex_f   = (req_q.size() != 0) && req_rdy;
    resp_f = resp_v && e_resp_rdy;
    wb_f   = (wb_q.size() != 0) && wb_rdy;

    if (ex_f) slv_q.push_back(req_q.pop_front());
    if (in_f) req_q.push_back(in_op);
    if (resp_f) begin
      if (ord_q.size() == 0 || ord_q[0] != resp.id) m_err = 1;
      if (ord_q.size() != 0) void'(ord_q.pop_front());
      if (slv_q.size() != 0) void'(slv_q.pop_front());
    end
    if (in_f) ord_q.push_back(in_op.id);
    if (wb_f) void'(wb_q.pop_front());
    if (resp_f) wb_q.push_back(resp);
    outst += int'(in_f) - int'(wb_f);
    l_in_f   = in_f;
    l_resp_f = resp_f;
    @(posedge clk_i); #1;
  endtask

  // One cycle of randomized dispatch / slave / writeback behaviour (probabilities in percent).
  task automatic drive_cycle(input int p_in, input int p_rdy, input int p_resp, input int p_wb);
    if (!in_v && issue_left > 0 && pct(p_in)) begin
      in_op = rand_op(next_id);
      next_id++;
      issue_left--;
      in_v = 1;
    end
    req_rdy = pct(p_rdy);
    wb_rdy  = pct(p_wb);
    if (!resp_v && pct(p_resp)) begin
      if (slv_q.size() != 0) begin
        resp = mk_res(slv_q[0]); resp_v = 1;
      end else if (req_q.size() != 0 && req_rdy) begin
        resp = mk_res(req_q[0]); resp_v = 1;   // zero-latency slave
      end
    end
    step();
    if (l_in_f) in_v = 0;
    if (l_resp_f) resp_v = 0;
  endtask

  task automatic drain(input string tag);
    int cyc = 0;
    while (!(issue_left == 0 && idle()) && cyc < 300) begin
      drive_cycle(100, 70, 70, 70);
      cyc++;
    end
    if (cyc >= 300) chk(tag, 0, 1);
  endtask

  task automatic single_op(input logic [IW-1:0] id);
    in_op = rand_op(id);
    in_op.rs1 = 32'h11;
    in_op.imm = 5'd3;
    in_v = 1; req_rdy = 1; wb_rdy = 1; resp_v = 0;
    step();
    in_v = 0;
    resp = '{id: id, rd: '0, vd: in_op.vs3};
    resp_v = 1;
    step();
    resp_v = 0;
    step();
    step();
    chk("single_done_busy", busy_o, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t a, b;
    int beats;
    rst_ni = 0;
    #3;
    chk("rst_req_valid", ex_req_valid_o, 0);
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_ni = 1;

    single_op(3'd2);

    // Streaming: ids 0..7, zero-latency slave, everything ready
    next_id = 0; issue_left = 8; beats = 0;
    for (int c = 0; c < 10; c++) begin
      if (wb_valid_o) beats++;
      drive_cycle(100, 100, 100, 100);
    end
    chk("stream_wb_beats", beats, 8);
    drain("stream_drain_timeout");

    // Credit limit: writeback stalled, 6 ops offered
    issue_left = 6;
    repeat (8) drive_cycle(100, 100, 100, 0);
    chk("credit_in_ready", in_ready_o, 0);
    chk("credit_busy", busy_o, 1);
    drain("credit_drain_timeout");

    // Back-pressure on the request channel
    issue_left = 1;
    drive_cycle(100, 100, 0, 100);
    repeat (5) drive_cycle(100, 0, 0, 100);
    chk("bp_req_held", ex_req_valid_o, 1);
    drain("bp_drain_timeout");

    // Out-of-order response: ids 1, 2 issued, 2 answered first
    next_id = 1; issue_left = 2;
    repeat (4) drive_cycle(100, 100, 0, 100);
    a = slv_q[0]; b = slv_q[1];
    req_rdy = 1; wb_rdy = 1;
    resp = mk_res(b); resp_v = 1;
    step();
    resp = mk_res(a);
    step();
    resp_v = 0;
    step();
    step();
    chk("order_err_sticky", err_o, 1);
    drain("order_drain_timeout");

    // Reset with three ops in flight and a result waiting on writeback
    issue_left = 3;
    repeat (4) drive_cycle(100, 100, 100, 0);
    rst_ni = 0;
    #1;
    chk("mid_rst_req_valid", ex_req_valid_o, 0);
    chk("mid_rst_wb_valid", wb_valid_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_err", err_o, 0);
    model_clear();
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_ni = 1;
    single_op(3'd5);
    chk("post_rst_err", err_o, 0);

    // Randomized traffic in epochs of varying pressure
    issue_left = 3000;
    for (int e = 0; e < 25; e++) begin
      int pi, pr, ps, pw;
      pi = $urandom_range(20, 100);
      pr = $urandom_range(10, 100);
      ps = $urandom_range(10, 100);
      pw = $urandom_range(10, 100);
      repeat (100) drive_cycle(pi, pr, ps, pw);
    end
    issue_left = 0;
    drain("rand_drain_timeout");
    chk("rand_final_busy", busy_o, 0);
    chk("rand_final_err", err_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
